// File: rtl/err_eval_pkg.sv
// Shared widths, sequencer state encoding and the metric record for the
// approximate-squarer error evaluation sweep.
package err_eval_pkg;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned OUT_W = 14;
  localparam int unsigned ACC_W = IN_W + OUT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [IN_W:0]    err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [OUT_W-1:0] max_abs_err;
    logic [IN_W-1:0]  worst_vec;
  } metrics_t;

endpackage

// File: rtl/err_abs_diff.sv
// Combinational |a-b| for two unsigned operands, with a flag that is set
// whenever the operands differ.
module err_abs_diff #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] abs_diff,
  output logic         nonzero
);

  logic [W:0] diff;

  // The borrow bit picks between the difference and its two's complement;
  // either way the magnitude fits in W bits.
  always_comb begin
    diff     = {1'b0, a} - {1'b0, b};
    abs_diff = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];
    nonzero  = |abs_diff;
  end

endmodule

// File: rtl/err_eval_sweep_ctrl.sv
// Sweeps every input vector through the approximate and exact squarers and
// accumulates mismatch count, sum / max absolute error and the worst vector.
module err_eval_sweep_ctrl
  import err_eval_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  vec_out,
  input  logic [OUT_W-1:0] approx_in,
  input  logic [OUT_W-1:0] exact_in,
  output logic             busy,
  output logic             done,
  output logic             complete,
  output logic [IN_W:0]    err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [OUT_W-1:0] max_abs_err,
  output logic [IN_W-1:0]  worst_vec
);

  state_t           state;
  metrics_t         met;
  metrics_t         met_nxt;
  logic             p1_valid;
  logic [IN_W-1:0]  p1_vec;
  logic [OUT_W-1:0] p1_approx;
  logic [OUT_W-1:0] p1_exact;
  logic [OUT_W-1:0] d;
  logic             d_nz;

  err_abs_diff #(
    .W(OUT_W)
  ) u_abs_diff (
    .a        (p1_approx),
    .b        (p1_exact),
    .abs_diff (d),
    .nonzero  (d_nz)
  );

  // Strictly-greater update keeps the lowest vector on ties.
  always_comb begin
    met_nxt = met;
    if (d_nz) begin
      met_nxt.err_count = met.err_count + (IN_W+1)'(1);
    end
    met_nxt.sum_abs_err = met.sum_abs_err + ACC_W'(d);
    if (d > met.max_abs_err) begin
      met_nxt.max_abs_err = d;
      met_nxt.worst_vec   = p1_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec_out   <= '0;
      met       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      complete  <= 1'b0;
      p1_valid  <= 1'b0;
      p1_vec    <= '0;
      p1_approx <= '0;
      p1_exact  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          p1_valid <= 1'b0;
          if (start) begin
            met      <= '0;
            complete <= 1'b0;
            vec_out  <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            p1_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            if (p1_valid) begin
              met <= met_nxt;
            end
            p1_valid  <= 1'b1;
            p1_vec    <= vec_out;
            p1_approx <= approx_in;
            p1_exact  <= exact_in;
            if (vec_out == '1) begin
              state <= DRAIN;
            end else begin
              vec_out <= vec_out + IN_W'(1);
            end
          end
        end
        DRAIN: begin
          p1_valid <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // The last vector is still pending in P1 and is folded in here.
            if (p1_valid) begin
              met <= met_nxt;
            end
            busy     <= 1'b0;
            done     <= 1'b1;
            complete <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign err_count   = met.err_count;
  assign sum_abs_err = met.sum_abs_err;
  assign max_abs_err = met.max_abs_err;
  assign worst_vec   = met.worst_vec;

endmodule

// File: tb/tb_err_eval_sweep_ctrl.sv
// Directed bench for err_eval_sweep_ctrl: stub squarers with planted errors,
// a sweep-level reference model checked every cycle, plus literal expectations.
module tb_err_eval_sweep_ctrl;
  import err_eval_pkg::*;

  localparam int N = 1 << IN_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  vec_out;
  logic [OUT_W-1:0] approx_in;
  logic [OUT_W-1:0] exact_in;
  logic             busy;
  logic             done;
  logic             complete;
  logic [IN_W:0]    err_count;
  logic [ACC_W-1:0] sum_abs_err;
  logic [OUT_W-1:0] max_abs_err;
  logic [IN_W-1:0]  worst_vec;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  err_eval_sweep_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .vec_out     (vec_out),
    .approx_in   (approx_in),
    .exact_in    (exact_in),
    .busy        (busy),
    .done        (done),
    .complete    (complete),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .worst_vec   (worst_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub datapaths: exact = v^2 truncated, approx = exact + planted offset.
  function automatic int sq(input int v);
    return (v * v) & ((1 << OUT_W) - 1);
  endfunction

  function automatic int offset(input int m, input int v);
    case (m)
      1: return 1;
      2: return (v == 'hABC) ? 300 : 0;
      3: begin
        if (v == 'h010) return 5;
        if (v == 'h020) return -5;
        if (v == 'hFFF) return 3;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int approx_of(input int m, input int v);
    return (sq(v) + offset(m, v)) & ((1 << OUT_W) - 1);
  endfunction

  function automatic int abs_err(input int m, input int v);
    int a;
    int e;
    a = approx_of(m, v);
    e = sq(v);
    return (a > e) ? a - e : e - a;
  endfunction

  always_comb begin
    exact_in  = OUT_W'(sq(int'(vec_out)));
    approx_in = OUT_W'(approx_of(mode, int'(vec_out)));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. m_t counts cycles since the start edge: 1..N+1 busy,
  // N+2 the done cycle, 0 idle. Metrics during cycle t cover vectors < t-2.
  bit        m_init = 0;
  int        m_t = 0;
  bit        m_vec_ok = 0;
  int        m_vec_idle = 0;
  bit        m_complete = 0;
  longint    m_cnt = 0;
  longint    m_sum = 0;
  int        m_max = 0;
  int        m_worst = 0;

  task automatic m_add(input int v);
    int d;
    d = abs_err(mode, v);
    if (d != 0) m_cnt++;
    m_sum += d;
    if (d > m_max) begin
      m_max   = d;
      m_worst = v;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_t = 0; m_vec_ok = 1; m_vec_idle = 0; m_complete = 0;
      m_cnt = 0; m_sum = 0; m_max = 0; m_worst = 0;
    end else if (m_t >= 1 && m_t <= N + 1) begin
      if (abort) begin
        m_t = 0;
        m_vec_ok = 0;
      end else begin
        if (m_t >= 2) m_add(m_t - 2);
        m_t++;
        if (m_t == N + 2) m_complete = 1;
      end
    end else if (m_t == N + 2) begin
      m_t = 0;
      m_vec_idle = N - 1;
    end else if (start) begin
      m_t = 1; m_vec_ok = 1; m_complete = 0;
      m_cnt = 0; m_sum = 0; m_max = 0; m_worst = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 64'(busy), 64'(m_t >= 1 && m_t <= N + 1));
      chk("done", 64'(done), 64'(m_t == N + 2));
      chk("complete", 64'(complete), 64'(m_complete));
      if (m_vec_ok)
        chk("vec_out", 64'(vec_out), 64'((m_t == 0) ? m_vec_idle : ((m_t - 1 < N - 1) ? m_t - 1 : N - 1)));
      chk("err_count", 64'(err_count), 64'(m_cnt));
      chk("sum_abs_err", 64'(sum_abs_err), 64'(m_sum));
      chk("max_abs_err", 64'(max_abs_err), 64'(m_max));
      chk("worst_vec", 64'(worst_vec), 64'(m_worst));
    end
  end

  // Starts a sweep (optionally with abort asserted alongside start) and
  // waits, bounded, for the done pulse; checks its cycle position.
  task automatic run_sweep(input bit with_abort);
    int cyc;
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cyc = 1;
    while (!done && cyc < N + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("sweep_done_seen", 64'(done), 64'(1));
    chk("done_cycle", 64'(cyc), 64'(N + 2));
    chk("complete_at_done", 64'(complete), 64'(1));
    @(negedge clk);
  endtask

  task automatic chk_metrics(input string tag, input int c, input int s, input int mx, input int wv);
    chk({tag, "_err_count"}, 64'(err_count), 64'(c));
    chk({tag, "_sum"}, 64'(sum_abs_err), 64'(s));
    chk({tag, "_max"}, 64'(max_abs_err), 64'(mx));
    chk({tag, "_worst"}, 64'(worst_vec), 64'(wv));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_vec", 64'(vec_out), 64'(0));
    chk_metrics("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Identity stub; start and abort together in IDLE, start wins.
    mode = 0;
    run_sweep(1'b1);
    chk_metrics("ident", 0, 0, 0, 0);
    chk("ident_complete", 64'(complete), 64'(1));

    mode = 1;
    run_sweep(1'b0);
    chk_metrics("plus1", 4096, 4096, 1, 'h000);

    mode = 2;
    run_sweep(1'b0);
    chk_metrics("single", 1, 300, 300, 'hABC);

    mode = 3;
    run_sweep(1'b0);
    chk_metrics("tie", 3, 13, 5, 'h010);

    // Abort during cycle 100: vectors 0..97 accumulated, 98 pending dropped.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_complete", 64'(complete), 64'(0));
    chk("abort_err_count", 64'(err_count), 64'(98));
    chk("abort_sum", 64'(sum_abs_err), 64'(98));
    repeat (3) @(negedge clk);
    run_sweep(1'b0);
    chk_metrics("rerun", 4096, 4096, 1, 'h000);

    // Start pulse while busy is ignored; reset mid-run clears everything.
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2949) @(negedge clk);
    chk("midrun_vec", 64'(vec_out), 64'(2999));
    chk("midrun_err_count", 64'(err_count), 64'(1));
    chk("midrun_sum", 64'(sum_abs_err), 64'(300));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_complete", 64'(complete), 64'(0));
    chk("rst_vec", 64'(vec_out), 64'(0));
    chk_metrics("rst", 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("idle_after_rst_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/err_eval_sweep_ctrl.md
Name: err_eval_sweep_ctrl

Overview:
- Sequencer for exhaustive error evaluation of one approximate squarer netlist against its exact counterpart.
- Sweeps every input vector, drives the shared vector into both datapaths, and accumulates the error metrics: mismatch count, sum of absolute error, maximum absolute error and the worst vector.
- Sits between the testbench/host and the combinational netlists; one sweep per start request.

Parameters:
- IN_W, 12, input vector width; the sweep covers 2^IN_W vectors.
- OUT_W, 14, datapath output width.
- ACC_W, IN_W+OUT_W, sum-of-absolute-error width; sized so the sum cannot overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  stop the sweep; honoured in RUN/DRAIN.
- vec_out  out  IN_W  vector driven to both datapaths.
- approx_in  in  OUT_W  approximate datapath result for vec_out (combinational return).
- exact_in  in  OUT_W  exact datapath result for vec_out (combinational return).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at sweep completion.
- complete  out  1  last sweep finished without abort.
- err_count  out  IN_W+1  number of vectors with approx != exact.
- sum_abs_err  out  ACC_W  sum of |approx-exact|.
- max_abs_err  out  OUT_W  largest |approx-exact|.
- worst_vec  out  IN_W  first vector achieving max_abs_err.

Behaviour:
- Reset (rst_n=0 at an edge) clears everything: state=IDLE; vec_out, all metrics, busy, done, complete=0; pipeline valid=0. Reset overrides start/abort in the same cycle.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> clear metrics, complete=0, vec_out=0, go to RUN.
  - Otherwise hold; metrics stay stable.
- RUN:
  - Each cycle capture {vec_out, approx_in, exact_in} into stage register P1 with valid=1.
  - vec_out increments by 1.
  - If vec_out == all-ones, vec_out holds and the state goes to DRAIN.
- Accumulate stage (every cycle P1 valid):
  - d = |approx-exact| on an OUT_W+1 intermediate; the result fits OUT_W.
  - If d != 0, err_count += 1.
  - sum_abs_err += d.
  - If d > max_abs_err (strictly greater), max_abs_err = d and worst_vec = P1 vector, so ties keep the lowest vector.
- DRAIN: P1 valid=0 after this cycle's accumulate; go to DONE.
- DONE: done=1 for exactly one cycle, complete=1, go to IDLE.
- Timing: start sampled at edge 0; vec_out=k during cycles 1..2^IN_W; DRAIN at cycle 2^IN_W+1; done high in cycle 2^IN_W+2.
- abort=1 in RUN or DRAIN -> IDLE next edge:
  - P1 valid cleared; pending P1 is not accumulated.
  - No done pulse; complete stays 0; partial metrics held.
- start outside IDLE is ignored; start and abort together in IDLE -> start wins.
- Wrap-around: vec_out never wraps past all-ones within a sweep.

Decomposition:
- Package err_eval_pkg:
  - width constants IN_W, OUT_W, ACC_W;
  - state enum typedef {IDLE, RUN, DRAIN, DONE};
  - metric struct typedef.
- Sub-module err_abs_diff: combinational |a-b| on OUT_W inputs, plus a nonzero flag. Instantiated once in the accumulate stage.

Test Plan:
- Identity stub (approx=exact=vec^2) -> err_count=0, sum_abs_err=0, max_abs_err=0, worst_vec=0, complete=1; done in cycle 4098 after start.
- approx=exact+1 for all vectors -> err_count=4096, sum_abs_err=4096, max_abs_err=1, worst_vec=0x000.
- Single fault, approx=exact+300 only at vec 0xABC -> err_count=1, sum_abs_err=300, max_abs_err=300, worst_vec=0xABC.
- Tie: error 5 at 0x010 and 0x020, error 3 at 0xFFF -> err_count=3, sum_abs_err=13, max_abs_err=5, worst_vec=0x010 (also checks the last vector is accumulated in DRAIN).
- abort at cycle 100, then start again -> no done on the first sweep, complete=0, busy drops next cycle. The second sweep is clean: metrics equal a fresh run.
- rst_n=0 mid-RUN, plus start pulses while busy -> all outputs 0 the next cycle, state IDLE; start during RUN does not restart vec_out.
